// File: rtl/sram_like_pkg.sv
// Shared constants and payload type for the SRAM-like arbiter slice.
package sram_like_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SZ_W   = 2;
    localparam int unsigned ID_W   = 1;

    localparam logic [ID_W-1:0] ID_INST = 1'b0;
    localparam logic [ID_W-1:0] ID_DATA = 1'b1;

    localparam logic [SZ_W-1:0] SIZE_B = 2'd0;
    localparam logic [SZ_W-1:0] SIZE_H = 2'd1;
    localparam logic [SZ_W-1:0] SIZE_W = 2'd2;

    // Request fields that travel together through the grant mux
    typedef struct packed {
        logic              wr;
        logic [SZ_W-1:0]   size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port: request side plus address/data handshakes and read data.
interface sram_like_arbiter_if;
    import sram_like_pkg::*;

    logic              req;
    logic              wr;
    logic [SZ_W-1:0]   size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding transactions; no push/pop bypass.
module id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;
    assign head      = mem_q[rd_ptr_q];

    // Pointers wrap modulo DEPTH, which need not be a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between IF and MEM requesters with in-order data return routing.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_arbiter_if.slave   inst_if,
    sram_like_arbiter_if.slave   data_if,
    sram_like_arbiter_if.master  mem_if
);

    sram_req_t         inst_pl_c;
    sram_req_t         data_pl_c;
    sram_req_t         mem_pl_c;
    logic [ID_W-1:0]   grant_c;
    logic              lock_hold_c;
    logic              mem_req_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [ID_W-1:0]   fifo_head_c;
    logic              locked_q, locked_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;

    assign inst_pl_c = {inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.addr, inst_if.wdata};
    assign data_pl_c = {data_if.wr, data_if.size, data_if.wstrb, data_if.addr, data_if.wdata};

    // A stalled request keeps the port until accepted or withdrawn
    always_comb begin
        lock_hold_c = 1'b0;
        grant_c     = ID_INST;
        if (locked_q) begin
            lock_hold_c = (lock_id_q == ID_DATA) ? data_if.req : inst_if.req;
        end
        if (lock_hold_c) begin
            grant_c = lock_id_q;
        end else if (data_if.req) begin
            grant_c = ID_DATA;
        end
    end

    assign mem_pl_c  = (grant_c == ID_DATA) ? data_pl_c : inst_pl_c;
    assign mem_req_c = resetn & (inst_if.req | data_if.req) & ~fifo_full_c;
    assign push_c    = mem_req_c & mem_if.addr_ok;
    assign pop_c     = mem_if.data_ok & ~fifo_empty_c;

    assign mem_if.req   = mem_req_c;
    assign mem_if.wr    = mem_pl_c.wr;
    assign mem_if.size  = mem_pl_c.size;
    assign mem_if.wstrb = mem_pl_c.wstrb;
    assign mem_if.addr  = mem_pl_c.addr;
    assign mem_if.wdata = mem_pl_c.wdata;

    assign inst_if.addr_ok = push_c & (grant_c == ID_INST);
    assign data_if.addr_ok = push_c & (grant_c == ID_DATA);
    assign inst_if.data_ok = pop_c & (fifo_head_c == ID_INST);
    assign data_if.data_ok = pop_c & (fifo_head_c == ID_DATA);
    assign inst_if.rdata   = mem_if.rdata;
    assign data_if.rdata   = mem_if.rdata;

    // Lock whenever the offered request is not taken this cycle
    always_comb begin
        locked_d  = 1'b0;
        lock_id_d = lock_id_q;
        if (mem_req_c && !mem_if.addr_ok) begin
            locked_d  = 1'b1;
            lock_id_d = grant_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked_q  <= 1'b0;
            lock_id_q <= ID_INST;
        end else begin
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push_c),
        .pop   (pop_c),
        .din   (grant_c),
        .head  (fifo_head_c),
        .full  (fifo_full_c),
        .empty (fifo_empty_c)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized bench for sram_like_arbiter against a transaction-level reference model.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if mem_if ();

    sram_like_arbiter #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst_if (inst_if),
        .data_if (data_if),
        .mem_if  (mem_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: owners of outstanding transactions, oldest first, and the stalled owner (-1 = none)
    int model_q[$];
    int stuck     = -1;
    bit in_reset  = 1'b1;
    bit e_mreq;
    int e_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                       input logic [31:0] daddr, input bit maok, input bit mdok,
                       input logic [31:0] rd);
        inst_if.req   = ireq;  inst_if.addr  = iaddr; inst_if.wr = 1'b0;
        inst_if.size  = SIZE_W; inst_if.wstrb = 4'h0;  inst_if.wdata = 32'h0;
        data_if.req   = dreq;  data_if.addr  = daddr; data_if.wr = 1'b0;
        data_if.size  = SIZE_W; data_if.wstrb = 4'h0;  data_if.wdata = 32'h0;
        mem_if.addr_ok = maok; mem_if.data_ok = mdok;  mem_if.rdata = rd;
    endtask

    // Let combinational outputs settle, then compare everything against the model
    task automatic settle(input string tag);
        bit ireq, dreq, maok, mdok, ne, full;
        int g, head, cnt;
        #2;
        ireq = inst_if.req;  dreq = data_if.req;
        maok = mem_if.addr_ok; mdok = mem_if.data_ok;
        cnt  = in_reset ? 0 : model_q.size();
        full = (cnt >= DEPTH);
        ne   = (cnt > 0);
        head = ne ? model_q[0] : 0;
        if (stuck >= 0 && ((stuck == 1) ? dreq : ireq)) g = stuck;
        else g = dreq ? 1 : 0;
        e_mreq = !in_reset && (ireq || dreq) && !full;
        e_g    = g;
        chk({tag, ".mem_req"},      32'(mem_if.req),      32'(e_mreq));
        chk({tag, ".inst_addr_ok"}, 32'(inst_if.addr_ok), 32'(e_mreq && maok && g == 0));
        chk({tag, ".data_addr_ok"}, 32'(data_if.addr_ok), 32'(e_mreq && maok && g == 1));
        chk({tag, ".inst_data_ok"}, 32'(inst_if.data_ok), 32'(mdok && ne && head == 0));
        chk({tag, ".data_data_ok"}, 32'(data_if.data_ok), 32'(mdok && ne && head == 1));
        chk({tag, ".inst_rdata"},   inst_if.rdata,        mem_if.rdata);
        chk({tag, ".data_rdata"},   data_if.rdata,        mem_if.rdata);
        chk({tag, ".count"},        32'(dut.u_fifo.count_q), 32'(cnt));
        if (e_mreq) begin
            chk({tag, ".mem_addr"},  mem_if.addr,  g ? data_if.addr  : inst_if.addr);
            chk({tag, ".mem_wdata"}, mem_if.wdata, g ? data_if.wdata : inst_if.wdata);
            chk({tag, ".mem_wr"},    32'(mem_if.wr),    32'(g ? data_if.wr    : inst_if.wr));
            chk({tag, ".mem_size"},  32'(mem_if.size),  32'(g ? data_if.size  : inst_if.size));
            chk({tag, ".mem_wstrb"}, 32'(mem_if.wstrb), 32'(g ? data_if.wstrb : inst_if.wstrb));
        end
    endtask

    // Advance one clock and apply the transaction rules to the model
    task automatic tick();
        @(posedge clk);
        if (!in_reset) begin
            if (mem_if.data_ok && model_q.size() > 0) void'(model_q.pop_front());
            if (e_mreq && mem_if.addr_ok) model_q.push_back(e_g);
            stuck = (e_mreq && !mem_if.addr_ok) ? e_g : -1;
        end
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drv(1'b1, 32'h1C000000, 1'b1, 32'h00001000, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        settle("reset"); tick();
        resetn = 1'b1; in_reset = 1'b0;

        // Priority: data wins when both request
        drv(1'b1, 32'h1C000000, 1'b1, 32'h00001000, 1'b1, 1'b0, 32'h0);
        settle("prio");
        chk("prio.addr", mem_if.addr, 32'h00001000);
        chk("prio.daok", 32'(data_if.addr_ok), 32'd1);
        chk("prio.iaok", 32'(inst_if.addr_ok), 32'd0);
        tick();
        chk("prio.head", 32'(dut.u_fifo.head), 32'(ID_DATA));
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
        settle("drain");
        chk("drain.ddok", 32'(data_if.data_ok), 32'd1);
        tick();

        // Lock: stalled inst keeps the port while data arrives
        drv(1'b1, 32'h1C000004, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        settle("lock1"); chk("lock1.addr", mem_if.addr, 32'h1C000004); tick();
        drv(1'b1, 32'h1C000004, 1'b1, 32'h00002000, 1'b0, 1'b0, 32'h0);
        settle("lock2"); chk("lock2.addr", mem_if.addr, 32'h1C000004); tick();
        settle("lock3"); chk("lock3.addr", mem_if.addr, 32'h1C000004); tick();
        mem_if.addr_ok = 1'b1;
        settle("lock4");
        chk("lock4.addr", mem_if.addr, 32'h1C000004);
        chk("lock4.iaok", 32'(inst_if.addr_ok), 32'd1);
        tick();
        drv(1'b0, 32'h0, 1'b1, 32'h00002000, 1'b1, 1'b0, 32'h0);
        settle("lock5");
        chk("lock5.addr", mem_if.addr, 32'h00002000);
        chk("lock5.daok", 32'(data_if.addr_ok), 32'd1);
        tick();

        // Full: two outstanding block a third request until after the first return
        drv(1'b1, 32'h1C000008, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle("full1"); chk("full1.mreq", 32'(mem_if.req), 32'd0); tick();
        drv(1'b1, 32'h1C000008, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA0000);
        settle("ord1");
        chk("ord1.mreq", 32'(mem_if.req), 32'd0);
        chk("ord1.idok", 32'(inst_if.data_ok), 32'd1);
        chk("ord1.ddok", 32'(data_if.data_ok), 32'd0);
        chk("ord1.rdata", inst_if.rdata, 32'hAAAA0000);
        tick();
        drv(1'b1, 32'h1C000008, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB0000);
        settle("ord2");
        chk("ord2.mreq", 32'(mem_if.req), 32'd1);
        chk("ord2.idok", 32'(inst_if.data_ok), 32'd0);
        chk("ord2.ddok", 32'(data_if.data_ok), 32'd1);
        chk("ord2.rdata", data_if.rdata, 32'hBBBB0000);
        tick();

        // Cancel: locked inst withdraws, pending data granted in the same cycle
        drv(1'b0, 32'h0, 1'b1, 32'h00003000, 1'b0, 1'b0, 32'h0);
        settle("cancel");
        chk("cancel.addr", mem_if.addr, 32'h00003000);
        chk("cancel.mreq", 32'(mem_if.req), 32'd1);
        tick();
        drv(1'b0, 32'h0, 1'b1, 32'h00003000, 1'b1, 1'b0, 32'h0);
        settle("cancel2"); tick();
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        settle("cancel3"); tick();

        // Spurious data_ok on an empty FIFO
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        settle("spur");
        chk("spur.idok", 32'(inst_if.data_ok), 32'd0);
        chk("spur.ddok", 32'(data_if.data_ok), 32'd0);
        tick();
        chk("spur.count", 32'(dut.u_fifo.count_q), 32'd0);

        // Reset with two outstanding
        drv(1'b1, 32'h1C00000C, 1'b1, 32'h00004000, 1'b1, 1'b0, 32'h0);
        settle("rst_a"); tick();
        drv(1'b1, 32'h1C00000C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle("rst_b"); tick();
        chk("rst.count2", 32'(dut.u_fifo.count_q), 32'd2);
        drv(1'b1, 32'h1C000010, 1'b1, 32'h00005000, 1'b1, 1'b0, 32'h0);
        resetn = 1'b0; in_reset = 1'b1;
        model_q.delete(); stuck = -1;
        settle("rst_mid");
        chk("rst.count0", 32'(dut.u_fifo.count_q), 32'd0);
        chk("rst.mreq", 32'(mem_if.req), 32'd0);
        tick();
        resetn = 1'b1; in_reset = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55AA55AA);
        settle("rst_late");
        chk("rst_late.idok", 32'(inst_if.data_ok), 32'd0);
        chk("rst_late.ddok", 32'(data_if.data_ok), 32'd0);
        tick();

        // Randomized traffic, including withdrawals and spurious returns
        for (int i = 0; i < 400; i++) begin
            drv(bit'($urandom_range(0, 99) < 55), $urandom, bit'($urandom_range(0, 99) < 45), $urandom,
                bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 99) < 45), $urandom);
            inst_if.wr    = 1'($urandom);
            inst_if.size  = 2'($urandom_range(0, 2));
            inst_if.wstrb = 4'($urandom);
            inst_if.wdata = $urandom;
            data_if.wr    = 1'($urandom);
            data_if.size  = 2'($urandom_range(0, 2));
            data_if.wstrb = 4'($urandom);
            data_if.wdata = $urandom;
            settle("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
